// File: rtl/turbo_pkg.sv
// turbo_pkg: shared definitions for the turbo decoder result packer.
//   - state_t         : packer FSM encoding
//   - TURBO_MAX_WORDS : default buffer depth in 64-bit words (6144-bit block)
//   - *_BIT           : bit positions inside the status word
//   - pick_half       : 64->32 half select; beat parity 0 = bits [31:0], 1 = bits [63:32]
package turbo_pkg;

    localparam int TURBO_MAX_WORDS = 96;

    localparam int CRC_OK_BIT  = 31;
    localparam int LEN_ERR_BIT = 30;
    localparam int DROP_BIT    = 29;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_STATUS  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Low half goes out first, so an even beat index selects [31:0].
    function automatic logic [31:0] pick_half(input logic [63:0] word, input logic hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/turbo_pack_buf.sv
// turbo_pack_buf: simple dual-port DEPTH x 64 result buffer.
//   clk   : clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address (sampled every cycle)
//   rdata : registered read data, mem[raddr] from the previous cycle
// No reset on the array or read register so it maps onto block RAM.
module turbo_pack_buf #(
    parameter int DEPTH = 96,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/turbo_result_packer.sv
// turbo_result_packer: captures the turbo decoder's 64-bit hard-decision words
// during restore and drains them as a 32-bit valid/ready stream.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   CB_length           : code block length in bits, sampled on the start pulse
//   Decode_Result_Start : one-cycle pulse, restore begins
//   Decode_Result_Addr  : restore address
//   Decode_result_D     : result word, RD_LAT cycles after its address
//   End_Decode          : restore complete
//   CRC_result          : 1 = CRC pass, sampled with the first End_Decode
//   out_data/out_valid/out_ready/out_last : output stream
//   busy                : FSM not idle
//   drop_err            : sticky, start pulse seen while busy
//
// Build option: define TURBO_PACK_STATUS_EN to append a status beat
// {crc_ok, len_err, drop_err, 16'b0, CB_length} after the payload; it then
// carries out_last. Without it, out_last marks the last payload beat and a
// bad-length block emits nothing.
module turbo_result_packer
    import turbo_pkg::*;
#(
    parameter int MAX_WORDS = TURBO_MAX_WORDS,
    parameter int ADDR_W    = 7,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [12:0]       CB_length,
    input  logic              Decode_Result_Start,
    input  logic [ADDR_W-1:0] Decode_Result_Addr,
    input  logic [63:0]       Decode_result_D,
    input  logic              End_Decode,
    input  logic              CRC_result,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              drop_err
);

`ifdef TURBO_PACK_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    localparam int WAW = $clog2(MAX_WORDS);

    state_t state, state_nxt;

    logic [12:0] cb_len;
    logic [6:0]  nwords;
    logic        len_err;
    logic        crc_ok;
    logic        ending;      // End_Decode already seen this block
    logic [7:0]  flush_cnt;   // cycles since End_Decode, to drain in-flight words
    logic [7:0]  ld_beat;     // next beat index to load into the output register
    logic        primed;      // first DRAIN cycle fetches word 0, nothing to load yet

    logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;
    logic [ADDR_W-1:0] d_addr;

    logic [6:0]  start_nw;
    logic        start_len_err;
    logic [7:0]  pay_total;
    logic [7:0]  rd_beat;
    logic        xfer, can_load, drain_end, cap_done;
    logic        buf_we;
    logic [WAW-1:0] buf_waddr, buf_raddr;
    logic [63:0] buf_rdata;
    logic [31:0] status_word;

    assign busy = (state != ST_IDLE);

    // ---------------- length decode ----------------
    assign start_nw      = CB_length[12:6];
    assign start_len_err = (start_nw == 7'd0) || (32'(start_nw) > MAX_WORDS)
                           || (CB_length[5:0] != 6'd0);
    assign pay_total     = {nwords, 1'b0};

    // ---------------- capture path ----------------
    // Delay the address so it lines up with its data word.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_pipe <= '1;
        end else begin
            addr_pipe[0] <= Decode_Result_Addr;
            for (int i = 1; i < RD_LAT; i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign d_addr    = addr_pipe[RD_LAT-1];
    // Out-of-range addresses (incl. the all-ones idle address) never write.
    assign buf_we    = (state == ST_CAPTURE) && !len_err && (32'(d_addr) < 32'(nwords));
    assign buf_waddr = WAW'(d_addr);
    assign cap_done  = (state == ST_CAPTURE) && ending && (int'(flush_cnt) == RD_LAT - 1);

    // ---------------- drain path ----------------
    assign xfer      = out_valid && out_ready;
    assign can_load  = (state == ST_DRAIN) && primed && (ld_beat < pay_total)
                       && (!out_valid || out_ready);
    // Last payload beat is leaving and nothing more to load.
    assign drain_end = (state == ST_DRAIN) && xfer && (ld_beat == pay_total);

    // Read-ahead: address the word for the beat that will be loaded next cycle,
    // so rdata is already valid when the output register wants it.
    assign rd_beat   = can_load ? 8'(ld_beat + 8'd1) : ld_beat;
    assign buf_raddr = (rd_beat < pay_total) ? WAW'(rd_beat >> 1) : '0;

    turbo_pack_buf #(
        .DEPTH (MAX_WORDS),
        .AW    (WAW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (Decode_result_D),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_comb begin
        status_word              = '0;
        status_word[CRC_OK_BIT]  = crc_ok;
        status_word[LEN_ERR_BIT] = len_err;
        status_word[DROP_BIT]    = drop_err;
        status_word[12:0]        = cb_len;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (Decode_Result_Start) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (cap_done) state_nxt = len_err ? (STATUS_EN ? ST_STATUS : ST_DONE)
                                                          : ST_DRAIN;
            ST_DRAIN:   if (drain_end) state_nxt = STATUS_EN ? ST_STATUS : ST_DONE;
            ST_STATUS:  if (xfer) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath / output register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cb_len    <= '0;
            nwords    <= '0;
            len_err   <= 1'b0;
            crc_ok    <= 1'b0;
            ending    <= 1'b0;
            flush_cnt <= '0;
            ld_beat   <= '0;
            primed    <= 1'b0;
            drop_err  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == ST_IDLE && Decode_Result_Start) begin
                cb_len    <= CB_length;
                nwords    <= start_nw;
                len_err   <= start_len_err;
                ending    <= 1'b0;
                flush_cnt <= '0;
                ld_beat   <= '0;
                primed    <= 1'b0;
            end

            if (state != ST_IDLE && Decode_Result_Start) begin
                drop_err <= 1'b1;
            end

            if (state == ST_CAPTURE) begin
                if (!ending && End_Decode) begin
                    ending <= 1'b1;
                    crc_ok <= CRC_result;
                end
                if (ending) begin
                    flush_cnt <= 8'(flush_cnt + 8'd1);
                end
            end

            if (state == ST_DRAIN) begin
                primed <= 1'b1;
            end

            if (can_load) begin
                out_valid <= 1'b1;
                out_data  <= pick_half(buf_rdata, ld_beat[0]);
                out_last  <= !STATUS_EN && (ld_beat == 8'(pay_total - 8'd1));
                ld_beat   <= 8'(ld_beat + 8'd1);
            end else if (drain_end) begin
                // Status beat replaces the last payload beat with no bubble.
                if (STATUS_EN) begin
                    out_valid <= 1'b1;
                    out_data  <= status_word;
                    out_last  <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (state == ST_STATUS) begin
                // Entered from CAPTURE on a bad length: nothing loaded yet.
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= status_word;
                    out_last  <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_turbo_result_packer.sv
module tb_turbo_result_packer;

`ifdef TURBO_PACK_STATUS_EN
    localparam bit ST_EN = 1'b1;
`else
    localparam bit ST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] CB_length;
    logic        Decode_Result_Start;
    logic [6:0]  Decode_Result_Addr;
    logic [63:0] Decode_result_D;
    logic        End_Decode;
    logic        CRC_result;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        drop_err;

    always #5 clk = ~clk;

    turbo_result_packer #(
        .MAX_WORDS (96),
        .ADDR_W    (7),
        .RD_LAT    (1)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .CB_length           (CB_length),
        .Decode_Result_Start (Decode_Result_Start),
        .Decode_Result_Addr  (Decode_Result_Addr),
        .Decode_result_D     (Decode_result_D),
        .End_Decode          (End_Decode),
        .CRC_result          (CRC_result),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_last            (out_last),
        .busy                (busy),
        .drop_err            (drop_err)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Decoder result word: high half tagged B0, low half A0, plus block tag and index.
    function automatic logic [63:0] word_of(input int tag, input int i);
        return {8'hB0, 8'(tag), 16'(i), 8'hA0, 8'(tag), 16'(i)};
    endfunction

    // ---------------- ready driver ----------------
    int rdy_mode = 0;  // 0: always ready, 1: toggle every cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : ~out_ready;
        end
    end

    // ---------------- stream monitor (negedge) ----------------
    logic [31:0] mon_data [$];
    logic        mon_last [$];
    int          mon_cyc  [$];
    int          cyc = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] data_prev  = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_hold", 32'(out_valid), 32'd1);
                chk("stall_data_hold", out_data, data_prev);
            end
            if (out_valid && out_ready) begin
                mon_data.push_back(out_data);
                mon_last.push_back(out_last);
                mon_cyc.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end
    end

    // ---------------- decoder model ----------------
    // inject: pulse a second start once 3 beats are out.
    // rst_at: assert reset once that many beats have transferred (0 = never).
    task automatic run_block(input logic [12:0] len, input int naddr, input int tag,
                             input logic crc, input bit inject, input int rst_at);
        int  n;
        bit  injected;
        bit  was_reset;
        mon_data.delete();
        mon_last.delete();
        mon_cyc.delete();
        injected  = 1'b0;
        was_reset = 1'b0;
        @(posedge clk); #1;
        chk("busy_before_start", 32'(busy), 32'd0);
        Decode_Result_Start = 1'b1;
        CB_length           = len;
        @(posedge clk); #1;
        chk("busy_after_start", 32'(busy), 32'd1);
        Decode_Result_Start = 1'b0;
        for (int i = 0; i < naddr; i++) begin
            Decode_Result_Addr = 7'(i);
            Decode_result_D    = (i > 0) ? word_of(tag, i - 1) : 64'd0;
            @(posedge clk); #1;
        end
        Decode_Result_Addr = '1;
        Decode_result_D    = word_of(tag, naddr - 1);
        End_Decode         = 1'b1;
        CRC_result         = crc;
        @(posedge clk); #1;
        End_Decode      = 1'b0;
        CRC_result      = ~crc;
        Decode_result_D = '0;
        n = 0;
        while (busy && n < 1000) begin
            if (inject && !injected && mon_data.size() >= 3) begin
                Decode_Result_Start = 1'b1;
                injected = 1'b1;
                @(posedge clk); #1;
                Decode_Result_Start = 1'b0;
            end else if (rst_at > 0 && !was_reset && mon_data.size() >= rst_at) begin
                reset = 1'b1;
                was_reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_mid_valid", 32'(out_valid), 32'd0);
                chk("rst_mid_busy", 32'(busy), 32'd0);
                chk("rst_mid_last", 32'(out_last), 32'd0);
                chk("rst_mid_drop", 32'(drop_err), 32'd0);
                reset = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string nm, input int tag, input int nw,
                                input logic [31:0] status);
        int exp_n;
        exp_n = 2 * nw + (ST_EN ? 1 : 0);
        chk({nm, "_count"}, 32'(mon_data.size()), 32'(exp_n));
        for (int b = 0; b < exp_n && b < mon_data.size(); b++) begin
            logic [63:0] w;
            logic [31:0] e;
            logic        el;
            if (b < 2 * nw) begin
                w  = word_of(tag, b / 2);
                e  = (b % 2 == 1) ? w[63:32] : w[31:0];
                el = !ST_EN && (b == exp_n - 1);
            end else begin
                e  = status;
                el = 1'b1;
            end
            chk({nm, "_data"}, mon_data[b], e);
            chk({nm, "_last"}, 32'(mon_last[b]), 32'(el));
        end
    endtask

    initial begin
        reset               = 1'b1;
        CB_length           = '0;
        Decode_Result_Start = 1'b0;
        Decode_Result_Addr  = '1;
        Decode_result_D     = '0;
        End_Decode          = 1'b0;
        CRC_result          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        reset = 1'b0;

        // 512-bit block, ready held high: contiguous stream
        rdy_mode = 0;
        run_block(13'd512, 8, 1, 1'b1, 1'b0, 0);
        check_stream("blk512", 1, 8, 32'h8000_0200);
        if (mon_cyc.size() == 16 + (ST_EN ? 1 : 0))
            chk("contiguous", 32'(mon_cyc[mon_cyc.size()-1] - mon_cyc[0]),
                32'(mon_cyc.size() - 1));
        else
            chk("contiguous_count", 32'(mon_cyc.size()), 32'(16 + (ST_EN ? 1 : 0)));

        // same block with ready toggling
        rdy_mode = 1;
        run_block(13'd512, 8, 2, 1'b1, 1'b0, 0);
        check_stream("toggle", 2, 8, 32'h8000_0200);
        rdy_mode = 0;

        // CRC fail
        run_block(13'd512, 8, 3, 1'b0, 1'b0, 0);
        check_stream("crcfail", 3, 8, 32'h0000_0200);

        // bad length, not a multiple of 64
        run_block(13'd100, 2, 4, 1'b1, 1'b0, 0);
        check_stream("len100", 4, 0, 32'h4000_0064);

        // too long: 97 words
        run_block(13'd6208, 3, 9, 1'b1, 1'b0, 0);
        check_stream("len6208", 9, 0, 32'h4000_1840);

        // maximum block, 96 words
        run_block(13'd6144, 96, 8, 1'b1, 1'b0, 0);
        check_stream("blkmax", 8, 96, 32'h9800_1800 & 32'h8000_1FFF);

        chk("drop_before", 32'(drop_err), 32'd0);

        // start pulse during DRAIN
        run_block(13'd512, 8, 5, 1'b1, 1'b1, 0);
        check_stream("drop", 5, 8, 32'hA000_0200);
        chk("drop_sticky", 32'(drop_err), 32'd1);

        // reset at beat 5, then a clean block
        run_block(13'd512, 8, 6, 1'b1, 1'b0, 5);
        run_block(13'd512, 8, 7, 1'b1, 1'b0, 0);
        check_stream("after_rst", 7, 8, 32'h8000_0200);
        chk("after_rst_drop", 32'(drop_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/turbo_result_packer.md
# turbo_result_packer

Downstream neighbour of the turbo decoder top. Captures the decoder's 64-bit hard-decision result words during its restore phase into a local buffer. The decoder has no backpressure, so this buffer is mandatory. It then drains the code block as a 32-bit valid/ready stream, optionally followed by one status word carrying the CRC verdict. One code block is handled at a time.

## Interface
Parameters:
- MAX_WORDS, 96: buffer depth in 64-bit words (6144-bit max code block).
- ADDR_W, 7: width of the decoder result address.
- RD_LAT, 1: cycles from `Decode_Result_Addr` to the matching `Decode_result_D`.

Ports (one clock; reset is synchronous and active-high; clock `clk`, reset `reset`):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- CB_length  in  13  code block length in bits; sampled on the start pulse
- Decode_Result_Start  in  1  one-cycle pulse, decoder restore begins
- Decode_Result_Addr  in  ADDR_W  restore address, increments once per cycle
- Decode_result_D  in  64  result word, valid RD_LAT cycles after its address
- End_Decode  in  1  decoder restore complete (level or pulse)
- CRC_result  in  1  1 = CRC pass; sampled when End_Decode is first seen
- out_data  out  32  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  final beat of the block
- busy  out  1  high in any state other than IDLE
- drop_err  out  1  sticky; a start pulse arrived while busy

## Operation
- States: IDLE, CAPTURE, DRAIN, STATUS, DONE.
- IDLE → CAPTURE on `Decode_Result_Start`.
  - Latch `CB_length`.
  - Compute `nwords = CB_length >> 6`.
  - Set `len_err` if `nwords == 0`, `nwords > MAX_WORDS`, or `CB_length[5:0] != 0`.
- CAPTURE:
  - `Decode_Result_Addr` is delayed by RD_LAT through a shift register.
  - Each cycle, if delayed address < `nwords` and `len_err == 0`, write `Decode_result_D` to `buf[delayed address]`.
  - Addresses ≥ `nwords`, including the decoder's all-ones idle address, are ignored.
- CAPTURE → DRAIN when `End_Decode` is first sampled high, plus RD_LAT cycles to flush in-flight words.
  - `CRC_result` is latched on that first End_Decode cycle.
  - If `len_err`, go to STATUS with the config macro defined, or to DONE without it.
- DRAIN:
  - Emit `2*nwords` beats in the order word0[31:0], word0[63:32], word1[31:0], and so on.
  - A beat transfers on `out_valid && out_ready`.
  - `out_data` is held stable while `out_valid && !out_ready`.
- DRAIN → STATUS after the last payload beat transfers, or → DONE when the status word is compiled out.
- STATUS emits one beat:
  - bit 31 = crc_ok
  - bit 30 = len_err
  - bit 29 = drop_err
  - bits 28:13 = 0
  - bits 12:0 = latched CB_length
- DONE → IDLE after one cycle.
- `out_last` is high on the final beat: the status beat when the macro is defined, otherwise the last payload beat.
- `Decode_Result_Start` outside IDLE: ignored, sets `drop_err`. `drop_err` clears only on reset.
- A start pulse on the same cycle as the DONE → IDLE transition is dropped.

## Timing
- Reset values:
  - out_valid = 0, out_last = 0, out_data = 0
  - busy = 0, drop_err = 0
  - state = IDLE
  - internal crc_ok = 0, len_err = 0, beat counter = 0
- Reset mid-operation aborts any block immediately, with no partial status. Buffer contents are don't-care.
- First `out_valid` is no later than 2 cycles after entering DRAIN (one cycle of buffer-read latency, plus output register).
- Throughput is 1 beat per cycle with `out_ready` held high. No bubbles across the word boundary or the payload→status boundary (the buffer is read-ahead).
- `busy` rises the cycle after the start pulse and falls the cycle after DONE.
- Handshake: once `out_valid` is asserted it is not deasserted until the beat transfers.

## Configuration
- `TURBO_PACK_STATUS_EN` defined: the STATUS beat is appended after the payload and carries `out_last`. A `len_err` block emits only the status beat.
- Undefined: no status beat. `out_last` marks the last payload beat. A `len_err` block emits nothing and returns to IDLE; it can be detected only through `busy` and bench-visible state.

## Structure
- Shared package `turbo_pkg`:
  - state encoding
  - MAX_WORDS
  - status bit positions (CRC_OK_BIT=31, LEN_ERR_BIT=30, DROP_BIT=29)
  - the 64→32 half-select convention
- Sub-module `turbo_pack_buf`: simple dual-port MAX_WORDS×64 RAM, one registered read port, inferable as block RAM. The FSM, counters and output register stay in the top.

## Test plan
- CB_length=512, addresses 0..7 then End_Decode, CRC_result=1, out_ready=1 → 16 contiguous payload beats in low/high-half order, then status 0x80000200 with out_last.
- Same block, out_ready toggling 1/0 every cycle → identical beat sequence. out_data stable during every stall.
- CRC_result=0 at End_Decode → payload intact, status bit 31 = 0 (0x00000200).
- CB_length=100 → no payload beats. Status 0x40000064 with the macro defined; nothing emitted and back to IDLE without it.
- Second Decode_Result_Start during DRAIN → ignored, stream unchanged, drop_err=1, status bit 29 set.
- reset asserted at beat 5 of DRAIN → next cycle out_valid=0, busy=0. A following 512-bit block decodes cleanly.
